// File: rtl/cpu_ctrl_fsm.sv
// Moore control sequencer for the multicycle CPU: fetch, PC update, decode and execute.
// Optional CPU_CTRL_ILLEGAL_TRAP_EN: illegal encodings halt with `illegal` set instead of acting as NOP.
module cpu_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU_OP,
        S_CMP_OP,
        S_WRITE_REG,
        S_ADDR_CALC,
        S_LOAD_ADDR,
        S_MEM_RD1,
        S_MEM_RD2,
        S_GET_RD,
        S_STR_PASS,
        S_MEM_WR,
        S_HALT,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // {opcode, op} encodings
    localparam logic [4:0] I_MOV_IMM = 5'b110_10;
    localparam logic [4:0] I_MOV_REG = 5'b110_00;
    localparam logic [4:0] I_MVN     = 5'b101_11;
    localparam logic [4:0] I_ADD     = 5'b101_00;
    localparam logic [4:0] I_CMP     = 5'b101_01;
    localparam logic [4:0] I_AND     = 5'b101_10;
    localparam logic [4:0] I_LDR     = 5'b011_00;
    localparam logic [4:0] I_STR     = 5'b100_00;
    localparam logic [2:0] OPC_HALT  = 3'b111;

    state_t state;
    ctrl_t  ctrl_q;

    function automatic state_t next_state(input state_t s, input logic [2:0] opc, input logic [1:0] o);
        logic [4:0] ins;
        ins        = {opc, o};
        next_state = S_RST;
        case (s)
            S_RST:       next_state = S_IF1;
            S_IF1:       next_state = S_IF2;
            S_IF2:       next_state = S_UPDATE_PC;
            S_UPDATE_PC: next_state = S_DECODE;
            S_DECODE: begin
                case (ins)
                    I_MOV_IMM:                        next_state = S_WRITE_IMM;
                    I_MOV_REG, I_MVN:                 next_state = S_GET_B;
                    I_ADD, I_CMP, I_AND, I_LDR, I_STR: next_state = S_GET_A;
                    default: begin
                        if (opc == OPC_HALT) begin
                            next_state = S_HALT;
                        end else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                            next_state = S_TRAP;
`else
                            next_state = S_IF1;
`endif
                        end
                    end
                endcase
            end
            S_GET_A:     next_state = (ins == I_LDR || ins == I_STR) ? S_ADDR_CALC : S_GET_B;
            S_GET_B:     next_state = (ins == I_CMP) ? S_CMP_OP : S_ALU_OP;
            S_ALU_OP:    next_state = S_WRITE_REG;
            S_CMP_OP:    next_state = S_IF1;
            S_WRITE_REG: next_state = S_IF1;
            S_WRITE_IMM: next_state = S_IF1;
            S_ADDR_CALC: next_state = S_LOAD_ADDR;
            S_LOAD_ADDR: next_state = (ins == I_LDR) ? S_MEM_RD1 : S_GET_RD;
            S_MEM_RD1:   next_state = S_MEM_RD2;
            S_MEM_RD2:   next_state = S_IF1;
            S_GET_RD:    next_state = S_STR_PASS;
            S_STR_PASS:  next_state = S_MEM_WR;
            S_MEM_WR:    next_state = S_IF1;
            S_HALT:      next_state = S_HALT;
            S_TRAP:      next_state = S_TRAP;
            default:     next_state = S_RST;
        endcase
    endfunction

    // Control word asserted while in state s
    function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] opc, input logic [1:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST: begin
                c.load_pc  = 1'b1;
                c.reset_pc = 1'b1;
            end
            S_IF1: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
                c.load_ir  = 1'b1;
            end
            S_UPDATE_PC: c.load_pc = 1'b1;
            S_WRITE_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM8;
                c.write = 1'b1;
            end
            S_GET_A: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GET_B: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALU_OP: begin
                c.asel  = ({opc, o} == I_MOV_REG) || ({opc, o} == I_MVN);
                c.loadc = 1'b1;
            end
            S_CMP_OP:    c.loads = 1'b1;
            S_WRITE_REG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_ADDR_CALC: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_LOAD_ADDR: c.load_addr = 1'b1;
            S_MEM_RD1:   c.mem_cmd = MEM_READ;
            S_MEM_RD2: begin
                c.mem_cmd = MEM_READ;
                c.nsel    = NSEL_RD;
                c.vsel    = VSEL_MDATA;
                c.write   = 1'b1;
            end
            S_GET_RD: begin
                c.nsel  = NSEL_RD;
                c.loadb = 1'b1;
            end
            S_STR_PASS: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_MEM_WR:    c.mem_cmd = MEM_WRITE;
            S_HALT:      c.halted = 1'b1;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                c.halted  = 1'b1;
                c.illegal = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    // Outputs are registered alongside the state so they always match it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_RST;
            ctrl_q <= ctrl_for(S_RST, 3'b000, 2'b00);
        end else begin
            state  <= next_state(state, opcode, op);
            ctrl_q <= ctrl_for(next_state(state, opcode, op), opcode, op);
        end
    end

    assign nsel      = ctrl_q.nsel;
    assign vsel      = ctrl_q.vsel;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign write     = ctrl_q.write;
    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign halted    = ctrl_q.halted;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: wraps the sequencer in a small behavioural CPU datapath and
// runs a short directed program, checking architectural results and cycle counts.
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted, illegal;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cpu_ctrl_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .write(write), .load_ir(load_ir),
        .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel),
        .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted), .illegal(illegal)
    );

    // Behavioural datapath, register file, PC, IR and synchronous RAM
    logic [15:0] mem [0:511];
    logic [15:0] rf [0:7];
    logic [8:0]  pc, dar;
    logic [15:0] ir, mdata, ra, rb, rc;
    logic        z;

    logic [2:0]  rn, rd, rm, rsel;
    logic [15:0] sximm8, sximm5, ain, bin, alu, wdata;
    logic [8:0]  maddr;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign rsel   = (nsel == 3'b100) ? rn : (nsel == 3'b010) ? rd : rm;
    assign maddr  = addr_sel ? pc : dar;
    assign ain    = asel ? 16'h0000 : ra;
    assign bin    = bsel ? sximm5 : rb;

    always_comb begin
        alu = 16'h0000;
        case (op)
            2'b00: alu = ain + bin;
            2'b01: alu = ain - bin;
            2'b10: alu = ain & bin;
            2'b11: alu = ~bin;
            default: ;
        endcase
    end

    always_comb begin
        wdata = rc;
        case (vsel)
            2'b00: wdata = rc;
            2'b01: wdata = {7'b0, pc};
            2'b10: wdata = sximm8;
            2'b11: wdata = mdata;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (load_pc) pc <= reset_pc ? 9'd0 : pc + 9'd1;
        if (mem_cmd == 2'b01) mdata <= mem[maddr];
        if (mem_cmd == 2'b10) mem[maddr] <= rc;
        if (load_ir) ir <= mdata;
        if (write) rf[rsel] <= wdata;
        if (loada) ra <= rf[rsel];
        if (loadb) rb <= rf[rsel];
        if (loadc) rc <= alu;
        if (loads) z <= (alu == 16'h0000);
        if (load_addr) dar <= rc[8:0];
    end

    logic [20:0] ctrl_vec;
    logic        in_if1;
    assign ctrl_vec = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, load_ir,
                       load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted, illegal};
    assign in_if1   = addr_sel && (mem_cmd == 2'b01) && !load_ir;

    int n_memwr, n_rfwr;
    logic wr_addr_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called while sampling IF1; returns once the next IF1 is seen (bounded)
    task automatic run_instr(input string tag, input int exp_cycles);
        int n;
        n = 0;
        n_memwr = 0;
        n_rfwr = 0;
        wr_addr_bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (mem_cmd == 2'b10) begin
                n_memwr++;
                if (addr_sel) wr_addr_bad = 1'b1;
            end
            if (write) n_rfwr++;
        end while (!in_if1 && n < 40);
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic wait_halt(input string tag);
        int k;
        k = 0;
        while (!halted && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        ir = 16'h0000; mdata = 16'h0000; ra = 16'h0000; rb = 16'h0000; rc = 16'h0000;
        z = 1'b0; dar = 9'd0;

        mem[0]  = 16'hD00A; // MOV R0,#10
        mem[1]  = 16'h6020; // LDR R1,[R0]
        mem[2]  = 16'hD20B; // MOV R2,#11
        mem[3]  = 16'h8220; // STR R1,[R2]
        mem[4]  = 16'hA062; // ADD R3,R0,R2
        mem[5]  = 16'hA800; // CMP R0,R0
        mem[6]  = 16'hB880; // MVN R4,R0
        mem[7]  = 16'hB2A0; // AND R5,R2,R0
        mem[8]  = 16'h0000; // illegal encoding
        mem[9]  = 16'hE000; // HALT
        mem[10] = 16'hABCD;

        // Reset behaviour
        @(negedge clk);
        check("rst_ctrl", 32'(ctrl_vec), 32'({3'b000, 2'b00, 8'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00}));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("pc_first_edge", 32'(pc), 32'd0);
        check("if1_after_rst", {31'b0, in_if1}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("pc_after_update", 32'(pc), 32'd1);

        // Reset mid-instruction, then run the program from IF1
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("if1_ctrl", 32'(ctrl_vec), 32'({3'b000, 2'b00, 8'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00}));
        check("pc_restart", 32'(pc), 32'd0);

        run_instr("mov_imm_cycles", 5);
        check("r0", 32'(rf[0]), 32'h000A);
        check("pc_after_mov", 32'(pc), 32'd1);

        run_instr("ldr_cycles", 9);
        check("r1", 32'(rf[1]), 32'hABCD);
        check("pc_after_ldr", 32'(pc), 32'd2);

        run_instr("mov_imm2_cycles", 5);
        check("r2", 32'(rf[2]), 32'h000B);

        run_instr("str_cycles", 10);
        check("mem11", 32'(mem[11]), 32'hABCD);
        check("str_write_count", 32'(n_memwr), 32'd1);
        check("str_write_addr_sel", {31'b0, wr_addr_bad}, 32'd0);
        check("str_no_rf_write", 32'(n_rfwr), 32'd0);
        check("pc_after_str", 32'(pc), 32'd4);

        run_instr("add_cycles", 8);
        check("r3", 32'(rf[3]), 32'h0015);

        run_instr("cmp_cycles", 7);
        check("z_flag", {31'b0, z}, 32'd1);
        check("cmp_no_rf_write", 32'(n_rfwr), 32'd0);

        run_instr("mvn_cycles", 7);
        check("r4", 32'(rf[4]), 32'hFFF5);

        run_instr("and_cycles", 8);
        check("r5", 32'(rf[5]), 32'h000A);
        check("pc_after_and", 32'(pc), 32'd8);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        wait_halt("illegal_halt");
        check("illegal_flag", {31'b0, illegal}, 32'd1);
        check("pc_at_trap", 32'(pc), 32'd9);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!halted || !illegal || pc != 9'd9) bad = 1;
        end
        check("trap_hold", 32'(bad), 32'd0);
`else
        run_instr("illegal_nop_cycles", 4);
        check("illegal_flag_nop", {31'b0, illegal}, 32'd0);
        check("pc_after_nop", 32'(pc), 32'd9);
        wait_halt("halt_reached");
        check("pc_at_halt", 32'(pc), 32'd10);
        check("halt_not_illegal", {31'b0, illegal}, 32'd0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!halted || illegal || pc != 9'd10) bad = 1;
        end
        check("halt_hold", 32'(bad), 32'd0);
`endif

        // Reset leaves the halt state asynchronously
        reset = 1'b1;
        #1;
        check("halted_cleared", {31'b0, halted}, 32'd0);
        check("illegal_cleared", {31'b0, illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("pc_after_halt_reset", 32'(pc), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
